// File: rtl/arb_pkg.sv
// Shared types and TileLink widths for the fetch/access bus arbiter.
package arb_pkg;

  localparam int unsigned TL_ADDR_W = 32;
  localparam int unsigned TL_DATA_W = 32;
  localparam int unsigned TL_MASK_W = TL_DATA_W / 8;
  localparam int unsigned TL_SIZE_W = 3;
  localparam int unsigned TL_OP_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP,
    DRAIN
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_MA
  } arb_owner_t;

endpackage

// File: rtl/tilelink.sv
// Minimal TileLink-UL A/D channel bundle used by the core memory ports.
interface tilelink;
  import arb_pkg::*;

  logic                 a_valid;
  logic                 a_ready;
  logic [TL_OP_W-1:0]   a_opcode;
  logic [TL_SIZE_W-1:0] a_size;
  logic [TL_ADDR_W-1:0] a_address;
  logic [TL_MASK_W-1:0] a_mask;
  logic [TL_DATA_W-1:0] a_data;
  logic                 d_valid;
  logic                 d_ready;
  logic [TL_OP_W-1:0]   d_opcode;
  logic [TL_DATA_W-1:0] d_data;

  modport master (
    output a_valid, a_opcode, a_size, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_data
  );

endinterface

// File: rtl/arb_pick.sv
// Next-owner selection for bus_arbiter.
// BUS_ARB_RR_EN: round-robin on contention; otherwise access stage has fixed priority.
module arb_pick
  import arb_pkg::*;
(
  input  logic       if_request,
  input  logic       ma_request,
`ifdef BUS_ARB_RR_EN
  input  arb_owner_t last_grant,
`endif
  output arb_owner_t pick
);

  // Owner for the next transaction; only consumed when some request is present.
  always_comb begin
`ifdef BUS_ARB_RR_EN
    if (if_request && ma_request) begin
      pick = (last_grant == OWN_MA) ? OWN_IF : OWN_MA;
    end else begin
      pick = ma_request ? OWN_MA : OWN_IF;
    end
`else
    pick = (if_request && !ma_request) ? OWN_IF : OWN_MA;
`endif
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter sharing one TileLink port between fetch and access stages.
// Ownership lasts one full A/D transaction; a flushed fetch response is drained.
// BUS_ARB_RR_EN selects round-robin arbitration (see arb_pick).
module bus_arbiter
  import arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clear,
  input  logic    if_request,
  tilelink.slave  if_bus,
  input  logic    ma_request,
  tilelink.slave  ma_bus,
  tilelink.master mem_bus,
  output logic    grant_if,
  output logic    grant_ma,
  output logic    busy
);

  arb_state_t state;
  arb_owner_t owner;
  arb_owner_t pick;
  logic       any_req;
  logic       flush_if;
  logic       drain_now;
  logic       a_fire;
  logic       d_fire;

`ifdef BUS_ARB_RR_EN
  arb_owner_t last_grant;
`endif

  arb_pick u_pick (
    .if_request (if_request),
    .ma_request (ma_request),
`ifdef BUS_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .pick       (pick)
  );

  assign any_req   = if_request || ma_request;
  assign flush_if  = clear && (owner == OWN_IF);
  // A flush during RESP drains on the same cycle so a coincident beat never reaches fetch.
  assign drain_now = (state == DRAIN) || ((state == RESP) && flush_if);
  assign a_fire    = mem_bus.a_valid && mem_bus.a_ready;
  assign d_fire    = mem_bus.d_valid && mem_bus.d_ready;

  // A channel: owner's request onto the shared port, ready back to the owner only.
  always_comb begin
    if (owner == OWN_MA) begin
      mem_bus.a_opcode  = ma_bus.a_opcode;
      mem_bus.a_size    = ma_bus.a_size;
      mem_bus.a_address = ma_bus.a_address;
      mem_bus.a_mask    = ma_bus.a_mask;
      mem_bus.a_data    = ma_bus.a_data;
      mem_bus.a_valid   = (state == ADDR) && ma_bus.a_valid;
    end else begin
      mem_bus.a_opcode  = if_bus.a_opcode;
      mem_bus.a_size    = if_bus.a_size;
      mem_bus.a_address = if_bus.a_address;
      mem_bus.a_mask    = if_bus.a_mask;
      mem_bus.a_data    = if_bus.a_data;
      mem_bus.a_valid   = (state == ADDR) && if_bus.a_valid;
    end
    if_bus.a_ready = (state == ADDR) && (owner == OWN_IF) && mem_bus.a_ready;
    ma_bus.a_ready = (state == ADDR) && (owner == OWN_MA) && mem_bus.a_ready;
  end

  // D channel: response to the owner unless draining; arbiter sinks the beat while draining.
  always_comb begin
    if_bus.d_opcode = mem_bus.d_opcode;
    if_bus.d_data   = mem_bus.d_data;
    ma_bus.d_opcode = mem_bus.d_opcode;
    ma_bus.d_data   = mem_bus.d_data;
    if_bus.d_valid  = (state == RESP) && (owner == OWN_IF) && !drain_now && mem_bus.d_valid;
    ma_bus.d_valid  = (state == RESP) && (owner == OWN_MA) && mem_bus.d_valid;
    mem_bus.d_ready = drain_now ||
                      ((state == RESP) && ((owner == OWN_MA) ? ma_bus.d_ready : if_bus.d_ready));
  end

  // Transaction FSM with owner register and registered grant/busy outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      grant_if <= 1'b0;
      grant_ma <= 1'b0;
      busy     <= 1'b0;
`ifdef BUS_ARB_RR_EN
      last_grant <= OWN_MA;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= ADDR;
            owner    <= pick;
            grant_if <= (pick == OWN_IF);
            grant_ma <= (pick == OWN_MA);
            busy     <= 1'b1;
`ifdef BUS_ARB_RR_EN
            last_grant <= pick;
`endif
          end
        end
        ADDR: begin
          // The A beat is never withdrawn mid-handshake: a flush that coincides
          // with acceptance must drain, otherwise nothing was issued.
          if (a_fire && flush_if) begin
            state    <= DRAIN;
            grant_if <= 1'b0;
          end else if (a_fire) begin
            state <= RESP;
          end else if (flush_if) begin
            state    <= IDLE;
            grant_if <= 1'b0;
            grant_ma <= 1'b0;
            busy     <= 1'b0;
          end
        end
        RESP: begin
          if (drain_now) begin
            grant_if <= 1'b0;
            if (mem_bus.d_valid) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end else if (d_fire) begin
            state    <= IDLE;
            grant_if <= 1'b0;
            grant_ma <= 1'b0;
            busy     <= 1'b0;
          end
        end
        DRAIN: begin
          if (mem_bus.d_valid) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          grant_if <= 1'b0;
          grant_ma <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: two master models, one memory slave model.
module tb_bus_arbiter;
  import arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clear, if_request, ma_request, grant_if, grant_ma, busy;

  tilelink if_bus ();
  tilelink ma_bus ();
  tilelink mem_bus ();

  bus_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .if_request (if_request),
    .if_bus     (if_bus),
    .ma_request (ma_request),
    .ma_bus     (ma_bus),
    .mem_bus    (mem_bus),
    .grant_if   (grant_if),
    .grant_ma   (grant_ma),
    .busy       (busy)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  // requested input values, applied at the start of the next tick
  logic rst_req, clr_req;
  logic if_pend, if_adone, ma_pend, ma_adone;
  logic [31:0] if_got, ma_got;
  int if_beats, ma_beats;
  logic if_dv_seen, ma_ar_while_if;

  // observation bookkeeping
  int tick_no, gif_cycles, stall_cnt, last_grant_tick;
  logic prev_gif, prev_gma;
  arb_owner_t grant_log[$];
  int gap_log[$];

  // slave model state
  int s_ph, s_stall, s_lat, s_wait, s_beats;
  logic [31:0] s_word, s_last_addr, s_last_data;
  logic [2:0] s_last_op;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge+1, slave reacts at +2, observe at +3.
  task automatic tick();
    @(negedge clk);
    #1;
    rst_n          = rst_req;
    clear          = clr_req;
    if_request     = if_pend;
    if_bus.a_valid = if_pend && !if_adone;
    if_bus.d_ready = 1'b1;
    ma_request     = ma_pend;
    ma_bus.a_valid = ma_pend && !ma_adone;
    ma_bus.d_ready = 1'b1;
    #2;
    tick_no++;
    if (mem_bus.a_valid && !mem_bus.a_ready) stall_cnt++;
    if (if_bus.d_valid) if_dv_seen = 1'b1;
    if (grant_if && ma_bus.a_ready) ma_ar_while_if = 1'b1;
    if (grant_if) gif_cycles++;
    if ((grant_if && !prev_gif) || (grant_ma && !prev_gma)) begin
      grant_log.push_back(grant_ma ? OWN_MA : OWN_IF);
      gap_log.push_back(tick_no - last_grant_tick - 1);
    end
    if (grant_if || grant_ma) last_grant_tick = tick_no;
    prev_gif = grant_if;
    prev_gma = grant_ma;
    if (if_bus.a_valid && if_bus.a_ready) if_adone = 1'b1;
    if (if_bus.d_valid && if_bus.d_ready) begin
      if_pend = 1'b0; if_adone = 1'b0; if_got = if_bus.d_data; if_beats++;
    end
    if (ma_bus.a_valid && ma_bus.a_ready) ma_adone = 1'b1;
    if (ma_bus.d_valid && ma_bus.d_ready) begin
      ma_pend = 1'b0; ma_adone = 1'b0; ma_got = ma_bus.d_data; ma_beats++;
    end
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while ((if_pend || ma_pend) && n < max) begin
      tick();
      n++;
    end
    check(tag, (if_pend || ma_pend) ? 32'd0 : 32'd1, 32'd1);
  endtask

  // Memory slave: optional a_ready stall, then d_valid s_lat idle cycles after the A beat.
  initial begin
    mem_bus.a_ready  = 1'b0;
    mem_bus.d_valid  = 1'b0;
    mem_bus.d_opcode = '0;
    mem_bus.d_data   = '0;
    forever begin
      @(negedge clk);
      #2;
      case (s_ph)
        0: begin
          mem_bus.d_valid = 1'b0;
          mem_bus.a_ready = 1'b0;
          if (mem_bus.a_valid === 1'b1) begin
            if (s_stall != 0) begin
              s_stall--;
            end else begin
              mem_bus.a_ready = 1'b1;
              s_last_addr = mem_bus.a_address;
              s_last_data = mem_bus.a_data;
              s_last_op   = mem_bus.a_opcode;
              s_wait      = s_lat;
              s_ph        = 1;
            end
          end
        end
        1: begin
          mem_bus.a_ready = 1'b0;
          if (s_wait != 0) begin
            s_wait--;
          end else begin
            mem_bus.d_valid  = 1'b1;
            mem_bus.d_data   = s_word;
            mem_bus.d_opcode = (s_last_op == 3'd4) ? 3'd1 : 3'd0;
            s_ph = 2;
          end
        end
        default: ;
      endcase
      if (s_ph == 2 && mem_bus.d_ready === 1'b1) begin
        s_beats++;
        s_ph = 0;
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    int n;
    int b0, m0;
    rst_req = 1'b0; clr_req = 1'b0;
    rst_n = 1'b0; clear = 1'b0; if_request = 1'b0; ma_request = 1'b0;
    if_pend = 1'b0; if_adone = 1'b0; ma_pend = 1'b0; ma_adone = 1'b0;
    if_got = '0; ma_got = '0; if_beats = 0; ma_beats = 0;
    if_dv_seen = 1'b0; ma_ar_while_if = 1'b0;
    tick_no = 0; gif_cycles = 0; stall_cnt = 0; last_grant_tick = 0;
    prev_gif = 1'b0; prev_gma = 1'b0;
    s_ph = 0; s_stall = 0; s_lat = 1; s_wait = 0; s_beats = 0;
    s_word = '0; s_last_addr = '0; s_last_data = '0; s_last_op = '0;
    if_bus.a_valid = 1'b0; if_bus.a_opcode = 3'd4; if_bus.a_size = 3'd2;
    if_bus.a_address = 32'h8000_0000; if_bus.a_mask = 4'hF; if_bus.a_data = '0;
    if_bus.d_ready = 1'b1;
    ma_bus.a_valid = 1'b0; ma_bus.a_opcode = 3'd0; ma_bus.a_size = 3'd2;
    ma_bus.a_address = 32'h8000_1000; ma_bus.a_mask = 4'hF; ma_bus.a_data = 32'h1234_5678;
    ma_bus.d_ready = 1'b1;

    // reset with both requests held
    if_pend = 1'b1; ma_pend = 1'b1;
    repeat (3) tick();
    check("reset_grant_if", {31'd0, grant_if}, 32'd0);
    check("reset_grant_ma", {31'd0, grant_ma}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_a_valid", {31'd0, mem_bus.a_valid}, 32'd0);
    rst_req = 1'b1;
    tick();
    tick();
`ifdef BUS_ARB_RR_EN
    check("release_grant_if", {31'd0, grant_if}, 32'd1);
    check("release_grant_ma", {31'd0, grant_ma}, 32'd0);
`else
    check("release_grant_ma", {31'd0, grant_ma}, 32'd1);
    check("release_grant_if", {31'd0, grant_if}, 32'd0);
`endif
    wait_done("release_done", 60);

    // lone fetch, two idle cycles before the response
    s_word = 32'h0000_0013; s_lat = 2; gif_cycles = 0;
    if_pend = 1'b1;
    wait_done("fetch_done", 50);
    check("fetch_data", if_got, 32'h0000_0013);
    check("fetch_addr", s_last_addr, 32'h8000_0000);
    check("fetch_grant_cycles", gif_cycles, 32'd4);
    tick();
    check("fetch_idle_busy", {31'd0, busy}, 32'd0);
    check("fetch_idle_grant", {31'd0, grant_if}, 32'd0);

    // contested: two rounds after a fetch, access stage first each round
    grant_log.delete(); gap_log.delete();
    s_word = 32'h0000_0077; s_lat = 1;
    for (int r = 0; r < 2; r++) begin
      if_pend = 1'b1; ma_pend = 1'b1;
      wait_done("contest_done", 60);
    end
    check("contest_data_if", if_got, 32'h0000_0077);
    check("contest_data_ma", ma_got, 32'h0000_0077);
    check("contest_count", grant_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("contest_order%0d", i), 32'(grant_log[i]),
            (i % 2 == 0) ? 32'(OWN_MA) : 32'(OWN_IF));
    end
    check("contest_gap", gap_log[1], 32'd1);

    // flush during a fetch response
    s_word = 32'h0000_DEAD; s_lat = 3; if_dv_seen = 1'b0;
    b0 = s_beats; m0 = if_beats;
    if_pend = 1'b1;
    n = 0;
    while (!if_adone && n < 20) begin tick(); n++; end
    check("flush_issued", {31'd0, if_adone}, 32'd1);
    clr_req = 1'b1; if_pend = 1'b0; if_adone = 1'b0;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (busy && n < 30) begin tick(); n++; end
    check("flush_idle", {31'd0, busy}, 32'd0);
    check("flush_d_valid", {31'd0, if_dv_seen}, 32'd0);
    check("flush_beat_sunk", s_beats - b0, 32'd1);
    check("flush_no_delivery", if_beats - m0, 32'd0);
    grant_log.delete();
    s_word = 32'h0000_0055; s_lat = 1;
    ma_pend = 1'b1;
    wait_done("post_flush_done", 40);
    check("post_flush_data", ma_got, 32'h0000_0055);
    check("post_flush_owner", 32'(grant_log[0]), 32'(OWN_MA));

    // flush during a store is ignored
    s_word = 32'h0; s_lat = 2; m0 = ma_beats;
    ma_pend = 1'b1;
    n = 0;
    while (!ma_adone && n < 20) begin tick(); n++; end
    clr_req = 1'b1;
    wait_done("store_done", 30);
    clr_req = 1'b0;
    check("store_ack", ma_beats - m0, 32'd1);
    check("store_data", s_last_data, 32'h1234_5678);
    check("store_addr", s_last_addr, 32'h8000_1000);

    // slave stalls a_ready while fetch owns the port and access waits
    tick();
    s_stall = 5; s_lat = 1; stall_cnt = 0; ma_ar_while_if = 1'b0;
    grant_log.delete(); gap_log.delete();
    if_pend = 1'b1;
    tick();
    ma_pend = 1'b1;
    wait_done("stall_done", 60);
    check("stall_cycles", stall_cnt, 32'd5);
    check("stall_ma_a_ready", {31'd0, ma_ar_while_if}, 32'd0);
    check("stall_first", 32'(grant_log[0]), 32'(OWN_IF));
    check("stall_second", 32'(grant_log[1]), 32'(OWN_MA));
    check("stall_gap", gap_log[1], 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
